// File: rtl/subckt_probe_scheduler_pkg.sv
// Shared types and defaults for the subcircuit probe scheduler.
package subckt_probe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_VEC_W = 4;
    localparam int DEF_HOLD  = 3;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/subckt_probe_scheduler_if.sv
// Harness-side request/response bus plus the subcircuit drive/observe pair.
interface subckt_probe_scheduler_if
    import subckt_probe_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int VEC_W = DEF_VEC_W
) ();
    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*VEC_W-1:0] req_vec;
    logic [NREQ-1:0]       req_ready;
    logic [VEC_W-1:0]      dut_in;
    logic                  dut_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_bit;
    logic                  busy;

    // Test harness / subcircuit side.
    modport master (
        output req_valid, req_vec, dut_out, rsp_ready,
        input  req_ready, dut_in, rsp_valid, rsp_id, rsp_bit, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_vec, dut_out, rsp_ready,
        output req_ready, dut_in, rsp_valid, rsp_id, rsp_bit, busy
    );
endinterface

// File: rtl/subckt_probe_scheduler_arbiter.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module subckt_rr_arbiter
    import subckt_probe_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_grant
);
    int              pos;
    logic [ID_W-1:0] idx;

    // Scan NREQ positions starting at rr_ptr; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = ID_W'(pos);
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/subckt_probe_scheduler.sv
// Shares one registered subcircuit among NREQ requesters: grant, hold vector, capture, respond.
module subckt_probe_scheduler
    import subckt_probe_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int VEC_W = DEF_VEC_W,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                    I1470_clk,
    input  logic                    I1477_rst,
    subckt_probe_scheduler_if.slave bus
);
    localparam int ID_W  = id_width(NREQ);
    localparam int CNT_W = (HOLD < 2) ? 1 : $clog2(HOLD + 1);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [ID_W-1:0]  id_latch;
    logic [VEC_W-1:0] vec_latch;
    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_idx;
    logic             any_grant;
    logic             take;
    logic             capture;
    logic [ID_W-1:0]  rsp_id_r;
    logic             rsp_bit_r;

    subckt_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // State register.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state and handshake decode; reset suppresses any grant in its cycle.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (any_grant && !I1477_rst) begin
                    take      = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (hold_cnt == CNT_W'(HOLD - 1)) begin
                    capture   = 1'b1;
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers: round-robin pointer, hold counter, response fields.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            rsp_id_r  <= '0;
            rsp_bit_r <= 1'b0;
        end else begin
            if (take) begin
                rr_ptr   <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
                hold_cnt <= '0;
            end else if (state == APPLY) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
            if (capture) begin
                rsp_bit_r <= bus.dut_out;
                rsp_id_r  <= id_latch;
            end
        end
    end

    // Granted vector and ID latch; only observed outside IDLE, so left unreset.
    always_ff @(posedge I1470_clk) begin
        if (take) begin
            vec_latch <= bus.req_vec[int'(grant_idx)*VEC_W +: VEC_W];
            id_latch  <= grant_idx;
        end
    end

    assign bus.req_ready = (state == IDLE && !I1477_rst) ? grant : '0;
    assign bus.dut_in    = (state == IDLE) ? '0 : vec_latch;
    assign bus.rsp_valid = (state == RESPOND);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_bit   = rsp_bit_r;
endmodule

// File: tb/tb_subckt_probe_scheduler.sv
// Randomized scoreboard bench for subckt_probe_scheduler with a timeline-based reference model.
module tb_subckt_probe_scheduler;
    import subckt_probe_pkg::*;

    localparam int NREQ  = 4;
    localparam int VEC_W = 4;
    localparam int HOLD  = 3;

    typedef struct {
        int id;
        int b;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subckt_probe_scheduler_if #(.NREQ(NREQ), .VEC_W(VEC_W)) bus ();

    subckt_probe_scheduler #(.NREQ(NREQ), .VEC_W(VEC_W), .HOLD(HOLD)) dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .bus       (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    rsp_t sb[$];

    // Expected combinational view of the current cycle, written by stimulus.
    logic [NREQ-1:0]  exp_ready;
    logic [VEC_W-1:0] exp_dut_in;
    logic             exp_rsp_valid;
    logic             exp_busy;
    bit               chk_en = 1'b0;

    // Reference model: grant timestamp (-1 when no transaction is in flight).
    int               m_rr  = 0;
    int               m_g   = -1;
    int               m_id  = 0;
    logic [VEC_W-1:0] m_vec = '0;
    int               cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, then advance the model along the transaction timeline.
    task automatic drive_cycle(input bit r, input logic [NREQ-1:0] rv,
                               input logic [NREQ*VEC_W-1:0] vec, input bit dout, input bit rdy);
        bit idle;
        int w;
        int j;
        @(posedge clk);
        #1;
        rst           = r;
        bus.req_valid = rv;
        bus.req_vec   = vec;
        bus.dut_out   = dout;
        bus.rsp_ready = r ? 1'b0 : rdy;

        idle = (m_g < 0);
        w    = -1;
        if (idle && !r) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_rr + k) % NREQ;
                if (w < 0 && ((rv >> j) & 1) != 0) w = j;
            end
        end
        exp_ready     = (w >= 0) ? (NREQ'(1) << w) : '0;
        exp_dut_in    = idle ? '0 : m_vec;
        exp_busy      = !idle;
        exp_rsp_valid = !idle && (cyc > m_g + HOLD);

        if (r) begin
            m_g  = -1;
            m_rr = 0;
            sb.delete();
        end else if (idle) begin
            if (w >= 0) begin
                m_g   = cyc;
                m_id  = w;
                m_vec = vec[w*VEC_W +: VEC_W];
                m_rr  = (w + 1) % NREQ;
            end
        end else if (cyc == m_g + HOLD) begin
            sb.push_back('{id: m_id, b: int'(dout)});
        end else if (cyc > m_g + HOLD && rdy) begin
            m_g = -1;
        end
        cyc++;
        chk_en = 1'b1;
    endtask

    function automatic logic [NREQ*VEC_W-1:0] rnd_vec();
        return (NREQ*VEC_W)'($urandom);
    endfunction

    // Monitor: compare per-cycle outputs and pop the scoreboard on each response handshake.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", int'(bus.req_ready), int'(exp_ready));
            check("dut_in", int'(bus.dut_in), int'(exp_dut_in));
            check("rsp_valid", int'(bus.rsp_valid), int'(exp_rsp_valid));
            check("busy", int'(bus.busy), int'(exp_busy));
            if (bus.rsp_valid && !rst) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_id", int'(bus.rsp_id), sb[0].id);
                    check("rsp_bit", int'(bus.rsp_bit), sb[0].b);
                    if (bus.rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_vec   = '0;
        bus.dut_out   = 1'b0;
        bus.rsp_ready = 1'b0;

        drive_cycle(1, '0, '0, 0, 0);
        drive_cycle(1, 4'b1111, rnd_vec(), 1, 1);
        @(negedge clk);
        check("reset_rsp_id", int'(bus.rsp_id), 0);
        check("reset_rsp_bit", int'(bus.rsp_bit), 0);

        // Single request from requester 1, vector A, observation tied high.
        drive_cycle(0, 4'b0010, 16'h00A0, 1, 1);
        for (int i = 0; i < 6; i++) drive_cycle(0, 4'b0000, rnd_vec(), 1, 1);

        // Continuous requests from everyone with an always-ready consumer; toggling observation.
        for (int i = 0; i < 40; i++) drive_cycle(0, 4'b1111, rnd_vec(), i[0], 1);

        // Backpressure: consumer stalls well past the respond entry.
        for (int i = 0; i < 16; i++) drive_cycle(0, 4'b1111, rnd_vec(), 1'($urandom), 0);
        for (int i = 0; i < 6; i++) drive_cycle(0, 4'b0000, rnd_vec(), 1'($urandom), 1);

        // Reset in the middle of an apply window, then 0 and 3 contend.
        drive_cycle(0, 4'b0100, rnd_vec(), 1, 1);
        drive_cycle(0, 4'b0000, rnd_vec(), 1, 1);
        drive_cycle(1, 4'b1001, rnd_vec(), 1, 1);
        for (int i = 0; i < 8; i++) drive_cycle(0, 4'b1001, rnd_vec(), 1'($urandom), 1);

        // Pointer wrap: only requester 3, then 0 and 3.
        drive_cycle(1, 4'b0000, rnd_vec(), 0, 0);
        drive_cycle(0, 4'b1000, rnd_vec(), 0, 1);
        for (int i = 0; i < 5; i++) drive_cycle(0, 4'b0000, rnd_vec(), 1'($urandom), 1);
        for (int i = 0; i < 8; i++) drive_cycle(0, 4'b1001, rnd_vec(), 1'($urandom), 1);

        // Fully random traffic with occasional resets and stalls.
        for (int i = 0; i < 600; i++) begin
            drive_cycle(($urandom_range(0, 49) == 0), NREQ'($urandom), rnd_vec(),
                        1'($urandom), ($urandom_range(0, 9) < 7));
        end

        // Drain anything outstanding.
        for (int i = 0; i < 3 * (HOLD + 2); i++) drive_cycle(0, '0, rnd_vec(), 1'($urandom), 1);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/subckt_probe_scheduler.md
# subckt_probe_scheduler

Round-robin scheduler that shares one registered Nt-node subcircuit (4 stimulus inputs, 1 registered observation output) among several test requesters. Each requester submits a stimulus vector; the block grants one requester at a time, drives the vector onto the subcircuit inputs, holds it until the subcircuit's flops have settled, captures the observed bit, and returns it tagged with the requester ID. It sits between the trojan-detection test harness ports and the subcircuit instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- VEC_W, 4, stimulus vector width (subcircuit input count)
- HOLD, 3, cycles the vector is held before capture (>= 1; must cover subcircuit flop depth + 1)
- I1470_clk  in  1  sole clock; all state updates on rising edge
- I1477_rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_vec  in  NREQ*VEC_W  per-requester vector, requester i at bits [i*VEC_W +: VEC_W]
- req_ready  out  NREQ  one-hot acceptance; at most one bit high
- dut_in  out  VEC_W  drive to subcircuit inputs
- dut_out  in  1  subcircuit observation output
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  $clog2(NREQ)  requester index of response
- rsp_bit  out  1  captured dut_out
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, APPLY, RESPOND.
- IDLE: req_ready = one-hot of first valid requester searching from rr_ptr upward with wrap; 0 if none valid. dut_in = 0. On handshake of requester g: latch vec_g and id g, hold_cnt <= 0, rr_ptr <= (g+1) mod NREQ, go APPLY.
- APPLY: req_ready = 0; dut_in = latched vector; hold_cnt increments each cycle. In the cycle hold_cnt == HOLD-1, rsp_bit <= dut_out and next state is RESPOND.
- RESPOND: rsp_valid = 1, rsp_id/rsp_bit stable; dut_in = latched vector (held). On rsp_ready: go IDLE (dut_in returns to 0 next cycle). No new grant in the handshake cycle.
- req_valid deassertion before grant: no effect, no state kept per requester. Requester may hold req_valid across its own grant; it re-arbitrates from the new rr_ptr.
- rr_ptr wraps NREQ-1 -> 0; it advances only on a grant.
- Outputs rsp_id, rsp_bit undefined-but-stable (hold last value) when rsp_valid = 0.

## Timing
- Reset values: state IDLE, rr_ptr 0, hold_cnt 0, dut_in 0, req_ready 0 during reset cycle, rsp_valid 0, rsp_id 0, rsp_bit 0, busy 0.
- Grant in cycle t -> dut_in = vector from t+1 through t+HOLD -> dut_out sampled at end of cycle t+HOLD -> rsp_valid high from t+HOLD+1.
- Minimum request-to-request throughput: HOLD+2 cycles (grant, HOLD apply, 1 respond with rsp_ready=1).
- rsp_ready low: RESPOND held indefinitely, all outputs stable, no grants.
- Reset asserted in any state: next cycle all reset values; in-flight transaction discarded, no response issued.
- Reset and req_valid same cycle: no grant.

## Structure
- Package subckt_probe_pkg: state enum (IDLE/APPLY/RESPOND), default NREQ/VEC_W/HOLD constants, id width function.
- Sub-module subckt_rr_arbiter: combinational round-robin picker (req vector, rr_ptr -> one-hot grant, grant index, any_grant). FSM, counter, latches stay in the top.

## Test plan (NREQ=4, VEC_W=4, HOLD=3)
- Reset then single request: req_valid=0010, vec1=4'hA, dut_out tied 1 -> req_ready=0010 at t, dut_in=4'hA t+1..t+4, rsp_valid at t+4 with rsp_id=1, rsp_bit=1.
- All requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0, one every 5 cycles; dut_in returns to 0 between transactions.
- Backpressure: rsp_ready=0 for 10 cycles in RESPOND -> rsp_valid stays 1, rsp_id/rsp_bit/dut_in stable, req_ready=0000; release -> IDLE next cycle.
- Capture timing: dut_out toggles each cycle -> rsp_bit equals dut_out value in cycle t+3, not t+2 or t+4.
- Reset in APPLY (hold_cnt=1) -> next cycle state IDLE, dut_in=0, rsp_valid never asserted, rr_ptr=0 (requester 0 wins next when 0 and 3 both valid).
- Wrap: only requester 3 granted, then 0 and 3 valid -> requester 0 granted next.
